// File: rtl/axi2ahb_pkg.sv
// Shared encodings for the AXI-to-AHB bridge: AHB HTRANS/HBURST, AXI AWBURST,
// FSM states, and the AXI burst to AHB HBURST mapping.
package axi2ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Fixed-length AHB bursts only exist for 4/8/16 beats; anything else
    // incrementing falls back to undefined-length INCR.
    function automatic logic [2:0] hburst_map(input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [2:0] hb;
        hb = HBURST_SINGLE;
        case (burst)
            AXI_BURST_FIXED: hb = HBURST_SINGLE;
            AXI_BURST_INCR: begin
                case (len)
                    8'd3:    hb = HBURST_INCR4;
                    8'd7:    hb = HBURST_INCR8;
                    8'd15:   hb = HBURST_INCR16;
                    default: hb = HBURST_INCR;
                endcase
            end
            AXI_BURST_WRAP: begin
                case (len)
                    8'd3:    hb = HBURST_WRAP4;
                    8'd7:    hb = HBURST_WRAP8;
                    8'd15:   hb = HBURST_WRAP16;
                    default: hb = HBURST_INCR;
                endcase
            end
            default: hb = HBURST_SINGLE;
        endcase
        return hb;
    endfunction

endpackage

// File: rtl/axi2ahb_addr_gen.sv
// Combinational next-beat address for AXI FIXED/INCR/WRAP bursts.
// Shared between the write-command and read-command paths.
module axi2ahb_addr_gen
    import axi2ahb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [7:0]                len,
    input  logic [2:0]                size,
    input  logic [1:0]                burst,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr
);

    logic [AXI_ADDR_WIDTH-1:0] step;
    logic [AXI_ADDR_WIDTH-1:0] incr_addr;
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;

    assign step      = AXI_ADDR_WIDTH'(1) << size;
    assign incr_addr = addr + step;
    // Window is (len+1) beats of the transfer size; legal WRAP lengths are
    // powers of two so the window minus one is a clean bit mask.
    assign wrap_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size)
                       - AXI_ADDR_WIDTH'(1);

    // Select the next address according to the latched burst type.
    always_comb begin
        next_addr = addr;
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_INCR:  next_addr = incr_addr;
            AXI_BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:         next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi2ahb_wcmd.sv
// AXI write-address channel to AHB address-phase converter.
// One AW command becomes one AHB burst; each beat is paced by the
// downstream write-data holder (ctrl_wdata_valid) and by HREADY.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | AWREADY high, AHB bus idle, waiting for an AW command
//   ST_BURST | issuing AHB address phases for the latched command
module axi2ahb_wcmd
    import axi2ahb_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic [AXI_ID_WIDTH-1:0]   AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,

    output logic [AXI_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                HTRANS,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    input  logic                      HREADY,

    output logic [AXI_ID_WIDTH-1:0]   cmd_id,
    input  logic                      ctrl_wdata_valid,
    input  logic                      ctrl_wdata_last,
    output logic                      ctrl_wdata_ready
);

    localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);

    state_t                    state;
    state_t                    state_nxt;

    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [2:0]                hburst_q;
    logic [7:0]                cnt;
    logic                      first;

    logic                      aw_fire;
    logic                      beat_acc;
    logic                      last_beat;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;

    assign aw_fire   = AWVALID && AWREADY;
    // NONSEQ and SEQ are the only HTRANS codes with bit 1 set.
    assign beat_acc  = HREADY && HTRANS[1];
    assign last_beat = (cnt == 8'd0);

    axi2ahb_addr_gen #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_next)
    );

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter a burst on AW handshake, leave after the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (aw_fire) state_nxt = ST_BURST;
            ST_BURST: if (beat_acc && last_beat) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: HTRANS follows ctrl_wdata_valid combinationally so a missing
    // data beat inserts BUSY (or IDLE before the first beat / in FIXED).
    always_comb begin
        AWREADY = 1'b0;
        HWRITE  = 1'b0;
        HTRANS  = HTRANS_IDLE;
        case (state)
            ST_IDLE: begin
                AWREADY = 1'b1;
            end
            ST_BURST: begin
                HWRITE = 1'b1;
                if (burst_q == AXI_BURST_FIXED) begin
                    HTRANS = ctrl_wdata_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
                end else if (ctrl_wdata_valid) begin
                    HTRANS = first ? HTRANS_NONSEQ : HTRANS_SEQ;
                end else begin
                    HTRANS = first ? HTRANS_IDLE : HTRANS_BUSY;
                end
            end
            default: begin
                AWREADY = 1'b1;
            end
        endcase
    end

    // Command latch on AW accept; address/counter advance on each beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= AXI_BURST_FIXED;
            hburst_q <= HBURST_SINGLE;
            cnt      <= 8'd0;
            first    <= 1'b0;
        end else if (aw_fire) begin
            id_q     <= AWID;
            addr_q   <= AWADDR;
            len_q    <= AWLEN;
            size_q   <= AWSIZE;
            burst_q  <= AWBURST;
            hburst_q <= hburst_map(AWBURST, AWLEN);
            cnt      <= AWLEN;
            first    <= 1'b1;
        end else if (beat_acc) begin
            first  <= 1'b0;
            addr_q <= addr_next;
            if (!last_beat) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    assign HADDR            = addr_q;
    assign HSIZE            = size_q;
    assign HBURST           = hburst_q;
    assign cmd_id           = id_q;
    assign ctrl_wdata_ready = beat_acc;

    // The data stage's last flag must agree with our own beat count.
    a_last_matches: assert property (@(posedge ACLK) disable iff (!ARESETN)
        beat_acc |-> (ctrl_wdata_last == last_beat));

    // Transfer size may not exceed the data bus width.
    a_size_legal: assert property (@(posedge ACLK) disable iff (!ARESETN)
        aw_fire |-> (int'(AWSIZE) <= MAX_SIZE));

endmodule

// File: tb/tb_axi2ahb_wcmd.sv
// Scoreboard bench for axi2ahb_wcmd: the stimulus pushes the expected bus
// state for every driven cycle, a monitor pops and compares on the falling edge.
module tb_axi2ahb_wcmd;

    localparam logic [1:0] T_I = 2'b00;
    localparam logic [1:0] T_B = 2'b01;
    localparam logic [1:0] T_N = 2'b10;
    localparam logic [1:0] T_S = 2'b11;

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_WRAP4  = 3'b010;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;
    localparam logic [2:0] B_INCR8  = 3'b101;

    localparam logic [1:0] A_FIXED = 2'b00;
    localparam logic [1:0] A_INCR  = 2'b01;
    localparam logic [1:0] A_WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hready = 1'b1;
    logic [0:0]  cmd_id;
    logic        wvalid = 1'b0;
    logic        wlast = 1'b0;
    logic        wready;

    typedef struct {
        logic        awr;
        logic [1:0]  tr;
        logic [31:0] addr;
        logic [2:0]  hb;
        logic [2:0]  hs;
        logic        id;
        logic        rdy;
        logic        chk;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    logic [2:0] e_burst = B_SINGLE;
    logic [2:0] e_size = 3'd0;
    logic       e_id = 1'b0;
    int         cyc_n = 0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    axi2ahb_wcmd #(
        .AXI_ID_WIDTH   (1),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32)
    ) dut (
        .ACLK             (clk),
        .ARESETN          (rst_n),
        .AWID             (awid),
        .AWADDR           (awaddr),
        .AWLEN            (awlen),
        .AWSIZE           (awsize),
        .AWBURST          (awburst),
        .AWVALID          (awvalid),
        .AWREADY          (awready),
        .HADDR            (haddr),
        .HTRANS           (htrans),
        .HWRITE           (hwrite),
        .HSIZE            (hsize),
        .HBURST           (hburst),
        .HREADY           (hready),
        .cmd_id           (cmd_id),
        .ctrl_wdata_valid (wvalid),
        .ctrl_wdata_last  (wlast),
        .ctrl_wdata_ready (wready)
    );

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, c, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest expectation each falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("awready", e.cyc, 32'(awready), 32'(e.awr));
            check("hwrite",  e.cyc, 32'(hwrite),  32'(!e.awr));
            check("htrans",  e.cyc, 32'(htrans),  32'(e.tr));
            check("wready",  e.cyc, 32'(wready),  32'(e.rdy));
            if (e.chk) begin
                check("haddr",  e.cyc, haddr,         e.addr);
                check("hburst", e.cyc, 32'(hburst),   32'(e.hb));
                check("hsize",  e.cyc, 32'(hsize),    32'(e.hs));
                check("cmd_id", e.cyc, 32'(cmd_id),   32'(e.id));
            end
        end
    end

    task automatic set_aw(input logic id, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
        awid = id;
        awaddr = a;
        awlen = l;
        awsize = s;
        awburst = b;
    endtask

    // One clock of stimulus plus the bus state expected during that clock.
    task automatic cyc(input logic rst, input logic awv, input logic wv,
                       input logic wl, input logic hr, input logic e_awr,
                       input logic [1:0] e_tr, input logic [31:0] e_addr,
                       input logic e_rdy, input logic chk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        awvalid = awv;
        wvalid = wv;
        wlast = wl;
        hready = hr;
        cyc_n++;
        e.awr = e_awr; e.tr = e_tr; e.addr = e_addr; e.hb = e_burst;
        e.hs = e_size; e.id = e_id; e.rdy = e_rdy; e.chk = chk; e.cyc = cyc_n;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset state, then released and idle
        cyc(0, 0, 0, 0, 1, 1, T_I, 32'h0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h0, 0, 1);

        // INCR4 at 0x100, data always valid
        set_aw(0, 32'h100, 8'd3, 3'd2, A_INCR);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h0, 0, 1);
        e_burst = B_INCR4; e_size = 3'd2; e_id = 1'b0;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h100, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h104, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h108, 1, 1);
        cyc(1, 0, 1, 1, 1, 0, T_S, 32'h10C, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h110, 0, 1);

        // WRAP4 at 0x38 wraps to window base 0x30
        set_aw(0, 32'h38, 8'd3, 3'd2, A_WRAP);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h110, 0, 1);
        e_burst = B_WRAP4;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h38, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h3C, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h30, 1, 1);
        cyc(1, 0, 1, 1, 1, 0, T_S, 32'h34, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h38, 0, 1);

        // INCR length 3 with two BUSY cycles after beat 0
        set_aw(0, 32'h200, 8'd2, 3'd2, A_INCR);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h38, 0, 1);
        e_burst = B_INCR;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h200, 1, 1);
        cyc(1, 0, 0, 0, 1, 0, T_B, 32'h204, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, T_B, 32'h204, 0, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h204, 1, 1);
        cyc(1, 0, 1, 1, 1, 0, T_S, 32'h208, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h20C, 0, 1);

        // INCR4 with HREADY low for three cycles on beat 1
        set_aw(0, 32'h300, 8'd3, 3'd2, A_INCR);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h20C, 0, 1);
        e_burst = B_INCR4;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h300, 1, 1);
        cyc(1, 0, 1, 0, 0, 0, T_S, 32'h304, 0, 1);
        cyc(1, 0, 1, 0, 0, 0, T_S, 32'h304, 0, 1);
        cyc(1, 0, 1, 0, 0, 0, T_S, 32'h304, 0, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h304, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h308, 1, 1);
        cyc(1, 0, 1, 1, 1, 0, T_S, 32'h30C, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h310, 0, 1);

        // FIXED two beats at 0x20 with ID 1; a gap gives IDLE, not BUSY
        set_aw(1, 32'h20, 8'd1, 3'd2, A_FIXED);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h310, 0, 1);
        e_burst = B_SINGLE; e_id = 1'b1;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h20, 1, 1);
        cyc(1, 0, 0, 0, 1, 0, T_I, 32'h20, 0, 1);
        cyc(1, 0, 1, 1, 1, 0, T_N, 32'h20, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h20, 0, 1);

        // INCR8 abandoned by reset after beat 1
        set_aw(0, 32'h400, 8'd7, 3'd2, A_INCR);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h20, 0, 1);
        e_burst = B_INCR8; e_id = 1'b0;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h400, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h404, 1, 1);
        e_burst = B_SINGLE; e_size = 3'd0; e_id = 1'b0;
        cyc(0, 0, 1, 0, 1, 1, T_I, 32'h0, 0, 1);
        cyc(0, 0, 1, 0, 1, 1, T_I, 32'h0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h0, 0, 1);

        // single-beat INCR after reset starts with NONSEQ
        set_aw(1, 32'h500, 8'd0, 3'd0, A_INCR);
        cyc(1, 1, 1, 1, 1, 1, T_I, 32'h0, 0, 1);
        e_burst = B_INCR; e_size = 3'd0; e_id = 1'b1;
        cyc(1, 0, 1, 1, 1, 0, T_N, 32'h500, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h501, 0, 1);

        // WRAP8 at 0x1C wraps within the 32-byte window at 0x00
        set_aw(0, 32'h1C, 8'd7, 3'd2, A_WRAP);
        cyc(1, 1, 1, 0, 1, 1, T_I, 32'h501, 0, 1);
        e_burst = B_WRAP8; e_size = 3'd2; e_id = 1'b0;
        cyc(1, 0, 1, 0, 1, 0, T_N, 32'h1C, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h00, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h04, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h08, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h0C, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h10, 1, 1);
        cyc(1, 0, 1, 0, 1, 0, T_S, 32'h14, 1, 1);
        cyc(1, 0, 1, 1, 1, 0, T_S, 32'h18, 1, 1);
        cyc(1, 0, 0, 0, 1, 1, T_I, 32'h1C, 0, 1);

        @(posedge clk);
        #1;
        check("scoreboard_drained", cyc_n, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi2ahb_wcmd.md
AXI2AHB_WCMD -- requirements
Module: axi2ahb_wcmd

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 1, width of AWID and cmd_id.
REQ-002 Parameter AXI_ADDR_WIDTH, default 32, width of AWADDR and HADDR.
REQ-003 Parameter AXI_DATA_WIDTH, default 32, bus data width; maximum legal AWSIZE is log2(AXI_DATA_WIDTH/8).
REQ-004 Port ACLK, in, 1: the single clock; all logic is rising-edge.
REQ-005 Port ARESETN, in, 1: asynchronous, active-low reset.
REQ-006 Ports AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID, in: the AXI write-address channel.
REQ-007 Port AWREADY, out, 1: AXI write-address ready.
REQ-008 Ports HADDR/HTRANS[1:0]/HWRITE/HSIZE[2:0]/HBURST[2:0], out: the AHB address phase.
REQ-009 Port HREADY, in, 1: AHB ready.
REQ-010 Port cmd_id, out, AXI_ID_WIDTH: ID of the current or most recent write command, consumed by the write-data stage for BID.
REQ-011 Ports ctrl_wdata_valid and ctrl_wdata_last, in, 1: a write-data beat is held downstream; last marks the final beat.
REQ-012 Port ctrl_wdata_ready, out, 1: the write beat is consumed by a completed AHB address phase.

Function
REQ-013 The FSM SHALL have two states: IDLE and BURST.
REQ-014 In IDLE, AWREADY=1, HTRANS=IDLE(00), and HWRITE=0.
REQ-015 On AWVALID&&AWREADY the block SHALL latch ID/ADDR/LEN/SIZE/BURST, load the beat counter with AWLEN, set first=1, and enter BURST.
REQ-016 In BURST, AWREADY=0 and HWRITE=1.
REQ-017 In BURST, HTRANS SHALL be combinational: ctrl_wdata_valid ? (first ? NONSEQ : SEQ) : (first ? IDLE : BUSY).
REQ-018 Exception for FIXED bursts: every beat SHALL be NONSEQ (IDLE when not valid).
REQ-019 A beat is accepted when HREADY=1 and HTRANS is NONSEQ or SEQ; ctrl_wdata_ready SHALL equal this condition in the same cycle.
REQ-020 On accept, the block SHALL clear first, decrement the counter, and load HADDR with the next address.
REQ-021 When the counter is 0 on accept, the FSM SHALL return to IDLE; AWREADY=1 in the next cycle.
REQ-022 While HREADY=0, HADDR, HSIZE, HBURST and HTRANS SHALL be held stable; ctrl_wdata_valid, once high, is held until ctrl_wdata_ready.
REQ-023 HSIZE SHALL equal the latched AWSIZE.
REQ-024 HBURST mapping: FIXED -> SINGLE; INCR with LEN+1 of 4/8/16 -> INCR4/8/16, otherwise INCR; WRAP with LEN+1 of 4/8/16 -> WRAP4/8/16.
REQ-025 Next address: FIXED unchanged; INCR addr+(1<<SIZE); WRAP increments within an aligned window of (LEN+1)<<SIZE bytes, wrapping to the window base.
REQ-026 INCR bursts SHALL NOT be split; AXI guarantees no 4KB crossing, and AHB 1KB crossings use INCR (undefined length).
REQ-027 cmd_id SHALL update only on AW accept and hold until the next accept.
REQ-028 ctrl_wdata_last SHALL be used only for checking and is expected to equal (counter==0) on accept.
REQ-029 HRESP is not an input; error responses are out of scope.
REQ-030 Latency: AW accepted in cycle N -> earliest NONSEQ in N+1 -> earliest next AWREADY one cycle after the last accept.

Reset
REQ-031 ARESETN low SHALL asynchronously force: state IDLE, AWREADY=1, HTRANS=IDLE, HWRITE=0, HADDR=0, HSIZE=0, HBURST=SINGLE, cmd_id=0, counter=0, first=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no further beats accepted; after release the block SHALL behave as after power-up.

Structure
REQ-033 Package axi2ahb_pkg SHALL hold the HTRANS, HBURST and AXI AWBURST encodings and the FSM state constants, shared with axi2ahb_wdata.
REQ-034 The next-address calculation (REQ-025) SHALL be a combinational sub-module, axi2ahb_addr_gen, reusable by the read path.

Verification
REQ-035 INCR AWADDR=0x100, LEN=3, SIZE=2, valid always high -> HBURST=INCR4, HTRANS NONSEQ,SEQ,SEQ,SEQ, HADDR 0x100/0x104/0x108/0x10C, 4 ctrl_wdata_ready pulses, AWREADY high the cycle after.
REQ-036 WRAP AWADDR=0x38, LEN=3, SIZE=2 -> HBURST=WRAP4, HADDR 0x38,0x3C,0x30,0x34.
REQ-037 INCR LEN=2 with ctrl_wdata_valid low for 2 cycles after beat 0 -> HBURST=INCR, HTRANS NONSEQ,BUSY,BUSY,SEQ,SEQ, HADDR held during BUSY.
REQ-038 HREADY low for 3 cycles during beat 1 -> HADDR/HTRANS stable, ctrl_wdata_ready low until HREADY rises, then a single pulse.
REQ-039 FIXED AWADDR=0x20, LEN=1, AWID=1 -> two NONSEQ, HBURST=SINGLE, HADDR 0x20 twice, cmd_id=1 throughout.
REQ-040 ARESETN asserted after beat 1 of an INCR8 -> HTRANS=IDLE and AWREADY=1 immediately; a new AW after release starts with NONSEQ.
